cc_scan_counter: RTL and testbench

CC_SCAN_COUNTER -- requirements
Module: cc_scan_counter

---
 rtl/cc_scan_counter_pkg.sv | 32 +++
 rtl/cc_scan_counter_prescaler.sv | 32 +++
 rtl/cc_scan_counter.sv | 148 ++++++++++++++
 tb/tb_cc_scan_counter.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/cc_scan_counter_pkg.sv
// Shared definitions for the display scan counter: FSM encodings, blank select code, index width.
// Latency: n/a (package only).
// Backpressure: n/a. GUARD state exists only when CC_SCAN_COUNTER_GHOST_BLANK_EN is defined.
package cc_scan_counter_pkg;

    // Up to four digits are scanned, so a 2-bit index covers every slot.
    localparam int         SCAN_IDX_W     = 2;
    // Selection code that tells the downstream decoder to blank all digits.
    localparam logic [2:0] SCAN_SEL_BLANK = 3'b111;

`ifdef CC_SCAN_COUNTER_GHOST_BLANK_EN
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_GUARD = 2'd2
    } scan_state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1
    } scan_state_t;
`endif

    // Next digit index with wrap from the last scanned digit back to 0.
    function automatic logic [SCAN_IDX_W-1:0] scan_next_index(
        input logic [SCAN_IDX_W-1:0] idx,
        input logic [SCAN_IDX_W-1:0] last
    );
        return (idx == last) ? '0 : idx + 1'b1;
    endfunction

endpackage

// File: rtl/cc_scan_counter_prescaler.sv
// Digit-slot prescaler: counts 0..PRESCALER_MAX-1 while enabled, tick on the terminal count.
// Latency: tick is asserted during the cycle the count register holds PRESCALER_MAX-1.
// Backpressure: none; clear has priority over counting and holds the count at 0.
module cc_scan_prescaler #(
    parameter int PRESCALER_MAX = 50000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_en,
    output logic o_tick
);

    localparam int CNT_W = (PRESCALER_MAX > 2) ? $clog2(PRESCALER_MAX) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALER_MAX - 1);

    logic [CNT_W-1:0] r_count;
    logic             w_last;

    assign w_last = (r_count == CNT_LAST);
    assign o_tick = i_en && w_last;

    // Free-running slot counter, wrapping to 0 after the terminal count.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= w_last ? '0 : r_count + 1'b1;
        end
    end

endmodule

// File: rtl/cc_scan_counter.sv
// Multiplexed display scanner: steps a digit index, drives select/value, double-buffers digit data.
// Latency: outputs registered; a digit changes one cycle after its prescaler tick.
// Backpressure: none; Enable_In low blanks next cycle. Optional macro CC_SCAN_COUNTER_GHOST_BLANK_EN.
module cc_scan_counter
    import cc_scan_counter_pkg::*;
#(
    parameter int DATAWIDTH_SCAN_SELECTION = 3,
    parameter int DATAWIDTH_SCAN_DIGIT     = 4,
    parameter int SCAN_NUM_DIGITS          = 4,
    parameter int SCAN_PRESCALER_MAX       = 50000
) (
    input  logic                                            CC_SCAN_COUNTER_CLOCK_50,
    input  logic                                            CC_SCAN_COUNTER_RESET_InHigh,
    input  logic                                            CC_SCAN_COUNTER_Enable_In,
    input  logic                                            CC_SCAN_COUNTER_Load_In,
    input  logic [SCAN_NUM_DIGITS*DATAWIDTH_SCAN_DIGIT-1:0] CC_SCAN_COUNTER_Data_In,
    output logic [DATAWIDTH_SCAN_SELECTION-1:0]             CC_SCAN_COUNTER_Selection_Out,
    output logic [DATAWIDTH_SCAN_DIGIT-1:0]                 CC_SCAN_COUNTER_Digit_Out,
    output logic                                            CC_SCAN_COUNTER_FrameDone_Out,
    output logic                                            CC_SCAN_COUNTER_Pending_Out
);

    localparam int DATA_W = SCAN_NUM_DIGITS * DATAWIDTH_SCAN_DIGIT;
    localparam logic [SCAN_IDX_W-1:0] IDX_LAST = SCAN_IDX_W'(SCAN_NUM_DIGITS - 1);
    localparam logic [DATAWIDTH_SCAN_SELECTION-1:0] SEL_BLANK =
        DATAWIDTH_SCAN_SELECTION'(SCAN_SEL_BLANK);

    scan_state_t                       r_state;
    logic [SCAN_IDX_W-1:0]             r_index;
    logic [DATA_W-1:0]                 r_active;
    logic [DATA_W-1:0]                 r_pending;
    logic                              r_pending_vld;
    logic [DATAWIDTH_SCAN_SELECTION-1:0] r_sel;
    logic [DATAWIDTH_SCAN_DIGIT-1:0]   r_digit;
    logic                              r_frame_done;

    logic                              w_presc_en;
    logic                              w_tick;
    logic                              w_wrap;
    logic                              w_xfer;
    logic [SCAN_IDX_W-1:0]             w_idx_next;
    logic [SCAN_IDX_W-1:0]             w_show_idx;
    logic [DATA_W-1:0]                 w_frame_data;
    logic [DATA_W-1:0]                 w_show_buf;
    logic [DATAWIDTH_SCAN_DIGIT-1:0]   w_show_digit;

    // Prescaler only runs while actively scanning; IDLE and GUARD keep it at 0.
    assign w_presc_en = (r_state == ST_SCAN) && CC_SCAN_COUNTER_Enable_In;

    cc_scan_prescaler #(
        .PRESCALER_MAX (SCAN_PRESCALER_MAX)
    ) u_prescaler (
        .i_clk   (CC_SCAN_COUNTER_CLOCK_50),
        .i_rst   (CC_SCAN_COUNTER_RESET_InHigh),
        .i_clear (!w_presc_en),
        .i_en    (w_presc_en),
        .o_tick  (w_tick)
    );

    // A frame boundary is either the wrap tick or leaving IDLE; pending data swaps in there.
    assign w_wrap       = w_tick && (r_index == IDX_LAST);
    assign w_xfer       = CC_SCAN_COUNTER_Enable_In && ((r_state == ST_IDLE) || w_wrap);
    assign w_idx_next   = scan_next_index(r_index, IDX_LAST);
    assign w_frame_data = r_pending_vld ? r_pending : r_active;
    // Use the incoming frame data on a boundary so digit 0 already shows it.
    assign w_show_buf   = w_xfer ? w_frame_data : r_active;
    assign w_show_digit = w_show_buf[int'(w_show_idx)*DATAWIDTH_SCAN_DIGIT +: DATAWIDTH_SCAN_DIGIT];

    // Index the display will show after this edge, per current state.
    always_comb begin
        w_show_idx = r_index;
        if (r_state == ST_IDLE) begin
            w_show_idx = '0;
        end else if (r_state == ST_SCAN) begin
            w_show_idx = w_idx_next;
        end
    end

    // Scan FSM with buffer management; every output is a register.
    always_ff @(posedge CC_SCAN_COUNTER_CLOCK_50) begin
        if (CC_SCAN_COUNTER_RESET_InHigh) begin
            r_state       <= ST_IDLE;
            r_index       <= '0;
            r_active      <= '0;
            r_pending     <= '0;
            r_pending_vld <= 1'b0;
            r_sel         <= SEL_BLANK;
            r_digit       <= '0;
            r_frame_done  <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            if (CC_SCAN_COUNTER_Load_In) begin
                r_pending <= CC_SCAN_COUNTER_Data_In;
            end
            // A load on the boundary cycle becomes the next pending frame.
            r_pending_vld <= CC_SCAN_COUNTER_Load_In || (r_pending_vld && !w_xfer);
            if (w_xfer && r_pending_vld) begin
                r_active <= r_pending;
            end

            if (!CC_SCAN_COUNTER_Enable_In) begin
                r_state <= ST_IDLE;
                r_index <= '0;
                r_sel   <= SEL_BLANK;
                r_digit <= '0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_state <= ST_SCAN;
                        r_index <= '0;
                        r_sel   <= DATAWIDTH_SCAN_SELECTION'(w_show_idx);
                        r_digit <= w_show_digit;
                    end
                    ST_SCAN: begin
                        if (w_tick) begin
                            r_index      <= w_idx_next;
                            r_frame_done <= w_wrap;
`ifdef CC_SCAN_COUNTER_GHOST_BLANK_EN
                            r_state <= ST_GUARD;
                            r_sel   <= SEL_BLANK;
                            r_digit <= '0;
`else
                            r_sel   <= DATAWIDTH_SCAN_SELECTION'(w_show_idx);
                            r_digit <= w_show_digit;
`endif
                        end
                    end
`ifdef CC_SCAN_COUNTER_GHOST_BLANK_EN
                    ST_GUARD: begin
                        r_state <= ST_SCAN;
                        r_sel   <= DATAWIDTH_SCAN_SELECTION'(w_show_idx);
                        r_digit <= w_show_digit;
                    end
`endif
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign CC_SCAN_COUNTER_Selection_Out = r_sel;
    assign CC_SCAN_COUNTER_Digit_Out     = r_digit;
    assign CC_SCAN_COUNTER_FrameDone_Out = r_frame_done;
    assign CC_SCAN_COUNTER_Pending_Out   = r_pending_vld;

endmodule

// File: tb/tb_cc_scan_counter.sv
// Self-checking bench for cc_scan_counter with a 4-clock slot and 4 digits.
// Latency: checks outputs 1 time unit after each rising edge.
// Backpressure: n/a; directed load/enable/reset vectors with hand-derived digit data.
module tb_cc_scan_counter;

`ifdef CC_SCAN_COUNTER_GHOST_BLANK_EN
    localparam int G = 1;
`else
    localparam int G = 0;
`endif
    localparam int DWELL = 4;
    localparam int P     = DWELL + G;          // cycles per digit slot incl. guard
    localparam int F     = 4 * P;              // cycles per frame
    localparam int FDPOS = (3 * P + DWELL) % F; // frame position carrying the pulse

    logic        clk;
    logic        rst;
    logic        en;
    logic        load;
    logic [15:0] data;
    logic [2:0]  sel;
    logic [3:0]  digit;
    logic        fd;
    logic        pend;

    int n_tests;
    int n_fail;
    int c;

    cc_scan_counter #(
        .DATAWIDTH_SCAN_SELECTION (3),
        .DATAWIDTH_SCAN_DIGIT     (4),
        .SCAN_NUM_DIGITS          (4),
        .SCAN_PRESCALER_MAX       (4)
    ) dut (
        .CC_SCAN_COUNTER_CLOCK_50      (clk),
        .CC_SCAN_COUNTER_RESET_InHigh  (rst),
        .CC_SCAN_COUNTER_Enable_In     (en),
        .CC_SCAN_COUNTER_Load_In       (load),
        .CC_SCAN_COUNTER_Data_In       (data),
        .CC_SCAN_COUNTER_Selection_Out (sel),
        .CC_SCAN_COUNTER_Digit_Out     (digit),
        .CC_SCAN_COUNTER_FrameDone_Out (fd),
        .CC_SCAN_COUNTER_Pending_Out   (pend)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests = n_tests + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s c=%0d got=%0h exp=%0h", tag, c, got, exp);
        end
    endtask

    function automatic int ppos(input int cc);
        return cc % F;
    endfunction

    // Expected select for cycle cc counted from the first SCAN cycle.
    function automatic int exp_sel(input int cc);
        int p;
        p = ppos(cc);
        return ((p % P) < DWELL) ? (p / P) : 7;
    endfunction

    function automatic logic exp_fd(input int cc);
        return (cc > 0) && (ppos(cc) == FDPOS);
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
        c = c + 1;
    endtask

    // Advance one cycle and check all four outputs against the frame data in effect.
    task automatic cyc_chk(input string tag, input logic [15:0] frame_data, input logic exp_pend);
        int          es;
        logic [3:0]  ed;
        cyc();
        es = exp_sel(c);
        ed = (es == 7) ? 4'h0 : frame_data[es*4 +: 4];
        chk({tag, "_sel"},   32'(sel),   32'(es));
        chk({tag, "_fd"},    32'(fd),    32'(exp_fd(c)));
        chk({tag, "_digit"}, 32'(digit), 32'(ed));
        chk({tag, "_pend"},  32'(pend),  32'(exp_pend));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1; en = 1'b0; load = 1'b0; data = 16'h0; c = -1;

        // Reset values
        cyc(); cyc();
        chk("rst_sel",   32'(sel),   32'h7);
        chk("rst_digit", 32'(digit), 32'h0);
        chk("rst_fd",    32'(fd),    32'h0);
        chk("rst_pend",  32'(pend),  32'h0);
        rst = 1'b0;
        cyc();
        chk("idle_sel", 32'(sel), 32'h7);

        // Free scan over a full frame plus the wrap
        en = 1'b1; c = -1;
        for (int i = 0; i <= F; i++) cyc_chk("scan", 16'h0000, 1'b0);

        // Mid-frame load, swap at wrap, digits 1,2,3,4
        while (ppos(c) != P + 1) cyc_chk("pre_b", 16'h0000, 1'b0);
        load = 1'b1; data = 16'h4321;
        cyc_chk("load_b", 16'h0000, 1'b1);
        load = 1'b0;
        while (ppos(c + 1) != FDPOS) cyc_chk("wait_b", 16'h0000, 1'b1);
        for (int i = 0; i < F; i++) cyc_chk("frame_b", 16'h4321, 1'b0);

        // Load AAAA mid-frame, then 5555 coincident with the wrap tick
        for (int i = 0; i < P + 1; i++) cyc_chk("pre_c", 16'h4321, 1'b0);
        load = 1'b1; data = 16'hAAAA;
        cyc_chk("load_c", 16'h4321, 1'b1);
        load = 1'b0;
        while (ppos(c + 1) != FDPOS) cyc_chk("wait_c", 16'h4321, 1'b1);
        load = 1'b1; data = 16'h5555;
        cyc_chk("wrap_c", 16'hAAAA, 1'b1);
        load = 1'b0;
        for (int i = 1; i < F; i++) cyc_chk("frame_c", 16'hAAAA, 1'b1);
        for (int i = 0; i < F; i++) cyc_chk("frame_c2", 16'h5555, 1'b0);

        // Drop enable at index 2, load while idle, re-enable
        while (ppos(c) != 2 * P) cyc_chk("pre_d", 16'h5555, 1'b0);
        en = 1'b0;
        cyc();
        chk("dis_sel",   32'(sel),   32'h7);
        chk("dis_digit", 32'(digit), 32'h0);
        chk("dis_fd",    32'(fd),    32'h0);
        chk("dis_pend",  32'(pend),  32'h0);
        load = 1'b1; data = 16'h9876;
        cyc();
        load = 1'b0;
        chk("idle_load_sel",  32'(sel),  32'h7);
        chk("idle_load_pend", 32'(pend), 32'h1);
        cyc();
        chk("idle_keep_pend", 32'(pend), 32'h1);
        chk("idle_keep_fd",   32'(fd),   32'h0);
        en = 1'b1; c = -1;
        for (int i = 0; i < 2 * P; i++) cyc_chk("re_d", 16'h9876, 1'b0);

        // Reset at index 3 with a pending frame, load asserted during reset
        load = 1'b1; data = 16'h1234;
        cyc_chk("load_e", 16'h9876, 1'b1);
        load = 1'b0;
        while (ppos(c) != 3 * P) cyc_chk("pre_e", 16'h9876, 1'b1);
        rst = 1'b1; load = 1'b1; data = 16'hFFFF;
        cyc();
        chk("rst_e_sel",   32'(sel),   32'h7);
        chk("rst_e_digit", 32'(digit), 32'h0);
        chk("rst_e_fd",    32'(fd),    32'h0);
        chk("rst_e_pend",  32'(pend),  32'h0);
        rst = 1'b0; load = 1'b0; c = -1;
        for (int i = 0; i < F; i++) cyc_chk("post_e", 16'h0000, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
